mem_arbiter: RTL and testbench

Word-level arbiter between the instruction cache and the data cache and the single-ported unified RAM. It sits directly downstream of the icache's `cache_control_if.icache` port, alongside the dcache port. Each cycle it grants at most one cache the RAM. It returns per-word wait/load to that cache and holds the other cache in wait. Dcache has priority, with a bounded starvation guard so instruction fetch always progresses.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and the memory arbiter grant state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Word-level arbiter granting the unified RAM to icache or dcache, dcache first,
// with a saturating counter that forces an icache grant after ISTARVE_MAX dcache words.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ISTARVE_MAX = 4,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output word_t             iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  word_t             dstore,
    output logic              dwait,
    output word_t             dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output word_t             ramstore,
    input  word_t             ramload,
    input  logic              ramready
);

    localparam int unsigned       SCNT_W   = $clog2(ISTARVE_MAX + 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(ISTARVE_MAX);

    ramstate_t         state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              dreq;
    logic              icomplete;
    logic              dcomplete;

    assign dreq      = dREN | dWEN;
    assign icomplete = (state_q == IGNT) && ramready;
    assign dcomplete = (state_q == DGNT) && ramready;

    assign iload = ramload;
    assign dload = ramload;

    function automatic ramstate_t pick(input logic dr, input logic ir,
                                       input logic [SCNT_W-1:0] cnt);
        if (dr && (cnt < SCNT_MAX)) begin
            return DGNT;
        end else if (ir) begin
            return IGNT;
        end else if (dr) begin
            return DGNT;
        end
        return IDLE;
    endfunction

    // The count includes the dcache word completing this cycle, so the grant decided
    // on that edge already sees it and exactly ISTARVE_MAX dcache words run back to back.
    always_comb begin
        scnt_d = scnt_q;
        if (!iREN || icomplete) begin
            scnt_d = '0;
        end else if (dcomplete && (scnt_q < SCNT_MAX)) begin
            scnt_d = scnt_q + SCNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            IDLE: begin
                state_d = pick(dreq, iREN, scnt_d);
            end
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !ramready;
                if (ramready) begin
                    state_d = pick(dreq, iREN, scnt_d);
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                // A simultaneous read and write is treated as a write.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !ramready;
                if (ramready) begin
                    state_d = pick(dreq, iREN, scnt_d);
                end else if (!dreq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a word-level memory and
// starvation model kept in the bench.
module tb_mem_arbiter;

    localparam int unsigned ISTARVE_MAX = 4;
    localparam int unsigned ADDR_W      = 32;
    localparam int          NRAND       = 40;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram_mem [0:63];
    logic [31:0] ref_mem [0:63];

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ISTARVE_MAX(ISTARVE_MAX),
        .ADDR_W     (ADDR_W)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramready(ramready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // icache holds one fetch while dcache streams reads; RAM answers in the first grant cycle.
    task automatic run_stream(input int nwords, output int ic_at, output int dn);
        int  budget;
        bit  idone;
        ic_at  = -1;
        dn     = 0;
        idone  = 0;
        budget = 0;
        iREN   = 1'b1;
        iaddr  = 32'h100;
        dREN   = 1'b1;
        dWEN   = 1'b0;
        daddr  = 32'h200;
        while ((dn < nwords || !idone) && budget < 200) begin
            tick();
            budget++;
            ramready = ramREN | ramWEN;
            ramload  = ramaddr ^ 32'h5A5A_0000;
            settle();
            if (!iwait) begin
                chk("stream_iload", iload, 32'h100 ^ 32'h5A5A_0000);
                ic_at = dn;
                idone = 1;
                iREN  = 1'b0;
            end
            if (!dwait) begin
                chk("stream_dload", dload, daddr ^ 32'h5A5A_0000);
                dn++;
                if (dn == nwords) dREN = 1'b0;
                else daddr = daddr + 32'd4;
            end
            settle();
        end
        chk("stream_budget", 32'(budget < 200), 32'd1);
        tick();
        ramready = 1'b0;
    endtask

    initial begin
        int ic_at, dn, b;
        int i_done, d_done, i_gap, d_gap, lat, consec, cyc;
        bit busy;

        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramready = 1'b0; ramload = 32'h0BAD_F00D;
        #3;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 32'h0BAD_F00D);
        chk("rst_dload", dload, 32'h0BAD_F00D);
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_en", {30'b0, ramREN, ramWEN}, 0);
            chk("idle_wait", {30'b0, iwait, dwait}, 3);
            chk("idle_addr", ramaddr, 0);
        end

        // Single icache word, RAM ready on the second grant cycle.
        iREN = 1'b1; iaddr = 32'h40; settle();
        chk("i_bubble_en", ramREN, 0);
        chk("i_bubble_wait", iwait, 1);
        tick();
        chk("i_g1_ren", ramREN, 1);
        chk("i_g1_addr", ramaddr, 32'h40);
        chk("i_g1_wait", iwait, 1);
        tick();
        ramready = 1'b1; ramload = 32'hDEAD_BEEF; settle();
        chk("i_g2_wait", iwait, 0);
        chk("i_g2_load", iload, 32'hDEAD_BEEF);
        chk("i_g2_dwait", dwait, 1);
        iREN = 1'b0; settle();
        tick();
        ramready = 1'b0; settle();
        chk("i_after_wait", iwait, 1);
        chk("i_after_ren", ramREN, 0);
        chk("i_after_dwait", dwait, 1);

        // Both caches in IDLE: dcache write first, then icache with no bubble.
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234; settle();
        chk("d_bubble_wen", ramWEN, 0);
        tick();
        chk("d_first_wen", ramWEN, 1);
        chk("d_first_ren", ramREN, 0);
        chk("d_first_addr", ramaddr, 32'h80);
        chk("d_first_store", ramstore, 32'h1234);
        chk("d_first_iwait", iwait, 1);
        ramready = 1'b1; settle();
        chk("d_done_dwait", dwait, 0);
        chk("d_done_iwait", iwait, 1);
        dWEN = 1'b0; settle();
        tick();
        ramready = 1'b0; settle();
        chk("i_nobubble_ren", ramREN, 1);
        chk("i_nobubble_addr", ramaddr, 32'h44);
        ramready = 1'b1; ramload = 32'hCAFE_0044; settle();
        chk("i_nobubble_wait", iwait, 0);
        chk("i_nobubble_load", iload, 32'hCAFE_0044);
        iREN = 1'b0; settle();
        tick();
        ramready = 1'b0; settle();

        // Starvation guard.
        run_stream(10, ic_at, dn);
        chk("starve_ic_at", 32'(ic_at), ISTARVE_MAX);
        chk("starve_dwords", 32'(dn), 10);

        // Read and write together is a write.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h84; dstore = 32'h5678; settle();
        tick();
        chk("rw_wen", ramWEN, 1);
        chk("rw_ren", ramREN, 0);
        ramready = 1'b1; settle();
        chk("rw_dwait", dwait, 0);
        dREN = 1'b0; dWEN = 1'b0; settle();
        tick();
        ramready = 1'b0; settle();

        // icache abandons its word before ramready.
        iREN = 1'b1; iaddr = 32'h48; settle();
        tick();
        chk("ab_ren", ramREN, 1);
        iREN = 1'b0; settle();
        chk("ab_ren_drop", ramREN, 0);
        chk("ab_iwait", iwait, 1);
        tick();
        chk("ab_idle_ren", ramREN, 0);
        chk("ab_idle_addr", ramaddr, 0);

        // Reset during a dcache grant after two starving dcache words.
        iREN = 1'b1; iaddr = 32'h10C; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h300;
        dn = 0; b = 0;
        while (dn < 2 && b < 20) begin
            tick();
            b++;
            ramready = ramREN | ramWEN; settle();
            if (!dwait) begin
                dn++;
                daddr = daddr + 32'd4;
            end
            settle();
        end
        chk("pre_rst_dwords", 32'(dn), 2);
        tick();
        ramready = 1'b0; settle();
        chk("pre_rst_ren", ramREN, 1);
        nRST = 1'b0; #1;
        chk("rst_mid_ren", ramREN, 0);
        chk("rst_mid_addr", ramaddr, 0);
        chk("rst_mid_dwait", dwait, 1);
        @(negedge CLK);
        nRST = 1'b1;
        run_stream(6, ic_at, dn);
        chk("rst_scnt_ic_at", 32'(ic_at), ISTARVE_MAX);

        // Randomized traffic against a word-level memory model.
        for (int k = 0; k < 64; k++) begin
            ram_mem[k] = $urandom;
            ref_mem[k] = ram_mem[k];
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
        i_done = 0; d_done = 0; i_gap = 0; d_gap = 0; consec = 0; cyc = 0; busy = 0; lat = 0;
        tick();
        while ((i_done < NRAND || d_done < NRAND) && cyc < 4000) begin
            if (!iREN && i_done < NRAND) begin
                if (i_gap == 0) begin
                    iREN  = 1'b1;
                    iaddr = 32'($urandom_range(0, 63)) << 2;
                end else begin
                    i_gap--;
                end
            end
            if (!dREN && !dWEN && d_done < NRAND) begin
                if (d_gap == 0) begin
                    case ($urandom_range(0, 2))
                        0:       begin dREN = 1'b1; dWEN = 1'b0; end
                        1:       begin dREN = 1'b0; dWEN = 1'b1; end
                        default: begin dREN = 1'b1; dWEN = 1'b1; end
                    endcase
                    daddr  = 32'($urandom_range(0, 63)) << 2;
                    dstore = $urandom;
                end else begin
                    d_gap--;
                end
            end
            settle();
            ramready = 1'b0;
            if (!(ramREN | ramWEN)) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    lat  = $urandom_range(0, 2);
                end
                if (lat == 0) begin
                    ramready = 1'b1;
                    busy     = 0;
                end else begin
                    lat--;
                end
            end
            ramload = ram_mem[ramaddr[7:2]];
            if (ramready && ramWEN) ram_mem[ramaddr[7:2]] = ramstore;
            settle();
            chk("rand_wait_excl", 32'(!iwait && !dwait), 0);
            if (!iwait) begin
                chk("rand_iload", iload, ref_mem[iaddr[7:2]]);
                i_done++;
                consec = 0;
                iREN   = 1'b0;
                i_gap  = $urandom_range(0, 3);
            end
            if (!dwait) begin
                if (dWEN) ref_mem[daddr[7:2]] = dstore;
                else chk("rand_dload", dload, ref_mem[daddr[7:2]]);
                if (iREN) begin
                    consec++;
                    chk("rand_starve_bound", 32'(consec <= int'(ISTARVE_MAX)), 1);
                end
                d_done++;
                dREN  = 1'b0;
                dWEN  = 1'b0;
                d_gap = $urandom_range(0, 1);
            end
            tick();
            cyc++;
        end
        chk("rand_i_done", 32'(i_done), NRAND);
        chk("rand_d_done", 32'(d_done), NRAND);
        for (int k = 0; k < 64; k++) begin
            chk("rand_mem_final", ram_mem[k], ref_mem[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
